// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the CLB configuration path: loader states, error codes,
// and the bit layout of a tile configuration word.
package fpga_cfg_pkg;

    localparam int         CFG_W     = 13;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_LO,
        ST_HI,
        ST_CHK,
        ST_COMMIT
    } loader_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_COUNT = 2'b01;
    localparam logic [1:0] ERR_PAD   = 2'b10;
    localparam logic [1:0] ERR_CHK   = 2'b11;

    // Field layout inside one tile word, as decoded by the CLB.
    localparam int FLD_MODE_LSB   = 0;
    localparam int FLD_MODE_W     = 2;
    localparam int FLD_A_SEL_LSB  = 2;
    localparam int FLD_A_SEL_W    = 3;
    localparam int FLD_B_SEL_LSB  = 5;
    localparam int FLD_B_SEL_W    = 3;
    localparam int FLD_ROUTE_LSB  = 8;
    localparam int FLD_ROUTE_W    = 4;
    localparam int FLD_USE_FF_BIT = 12;

endpackage

// File: rtl/clb_config_loader_if.sv
// Byte-stream link into the loader. A byte transfers on a clock edge where
// valid and ready are both high; valid low means no byte this cycle.
interface clb_config_loader_if;

    logic       valid;
    logic [7:0] data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/clb_config_bank.sv
// Shadow/active register pair for all tiles. The shadow is written word by word
// and the active bank, which drives the fabric, only ever changes on commit.
module clb_config_bank #(
    parameter int NUM_TILES = 16,
    parameter int CFG_W     = 13,
    parameter int IDX_W     = $clog2(NUM_TILES + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       load_i,
    input  logic                       wr_en_i,
    input  logic [IDX_W-1:0]           wr_idx_i,
    input  logic [CFG_W-1:0]           wr_data_i,
    input  logic                       commit_i,
    output logic [NUM_TILES*CFG_W-1:0] active_o
);

    logic [CFG_W-1:0] shadow_q [NUM_TILES];
    logic [CFG_W-1:0] active_q [NUM_TILES];

    for (genvar k = 0; k < NUM_TILES; k++) begin : g_tile
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                shadow_q[k] <= '0;
            end else if (load_i) begin
                shadow_q[k] <= active_q[k];
            end else if (wr_en_i && (wr_idx_i == IDX_W'(k))) begin
                shadow_q[k] <= wr_data_i;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                active_q[k] <= '0;
            end else if (commit_i) begin
                active_q[k] <= shadow_q[k];
            end
        end

        assign active_o[k*CFG_W +: CFG_W] = active_q[k];
    end

endmodule

// File: rtl/clb_config_loader.sv
// Parses SYNC/COUNT/{LO,HI}*N/CHK frames into the shadow bank and commits them
// to the active bank only when the XOR checksum matches.
module clb_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int         NUM_TILES = 16,
    parameter int         CFG_W     = fpga_cfg_pkg::CFG_W,
    parameter logic [7:0] SYNC_BYTE = fpga_cfg_pkg::SYNC_BYTE
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    clb_config_loader_if.slave         in_bus,
    output logic [NUM_TILES*CFG_W-1:0] cfg_o,
    output logic                       cfg_loaded_o,
    output logic                       commit_o,
    output logic                       busy_o,
    output logic                       err_o,
    output logic [1:0]                 err_code_o,
    output loader_state_e              state_o
);

    localparam int         IDX_W = $clog2(NUM_TILES + 1);
    localparam logic [7:0] MAX_N = 8'(NUM_TILES);

    loader_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [7:0]       lo_q, lo_d;
    logic [7:0]       chk_q, chk_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             loaded_q, loaded_d;

    logic             bank_load, bank_wr;
    logic [15:0]      word16;
    logic             pad_bad;

    assign in_bus.ready = (state_q != ST_COMMIT);
    assign word16       = {in_bus.data, lo_q};
    // Everything above the configuration width must be zero; a wide shift covers CFG_W == 16.
    assign pad_bad      = ((word16 >> CFG_W) != 16'd0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        lo_d      = lo_q;
        chk_d     = chk_q;
        err_d     = err_q;
        code_d    = code_q;
        loaded_d  = loaded_q;
        bank_load = 1'b0;
        bank_wr   = 1'b0;

        if (state_q == ST_COMMIT) begin
            loaded_d = 1'b1;
            state_d  = ST_IDLE;
        end else if (in_bus.valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_bus.data == SYNC_BYTE) begin
                        bank_load = 1'b1;
                        chk_d     = 8'd0;
                        err_d     = 1'b0;
                        code_d    = ERR_NONE;
                        state_d   = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if ((in_bus.data == 8'd0) || (in_bus.data > MAX_N)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_COUNT;
                        state_d = ST_IDLE;
                    end else begin
                        last_d  = IDX_W'(in_bus.data - 8'd1);
                        idx_d   = '0;
                        chk_d   = chk_q ^ in_bus.data;
                        state_d = ST_LO;
                    end
                end
                ST_LO: begin
                    lo_d    = in_bus.data;
                    chk_d   = chk_q ^ in_bus.data;
                    state_d = ST_HI;
                end
                ST_HI: begin
                    if (pad_bad) begin
                        err_d   = 1'b1;
                        code_d  = ERR_PAD;
                        state_d = ST_IDLE;
                    end else begin
                        bank_wr = 1'b1;
                        chk_d   = chk_q ^ in_bus.data;
                        if (idx_q == last_q) begin
                            state_d = ST_CHK;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_LO;
                        end
                    end
                end
                ST_CHK: begin
                    if (in_bus.data == chk_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHK;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            lo_q     <= '0;
            chk_q    <= '0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            lo_q     <= lo_d;
            chk_q    <= chk_d;
            err_q    <= err_d;
            code_q   <= code_d;
            loaded_q <= loaded_d;
        end
    end

    clb_config_bank #(
        .NUM_TILES (NUM_TILES),
        .CFG_W     (CFG_W),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (bank_load),
        .wr_en_i   (bank_wr),
        .wr_idx_i  (idx_q),
        .wr_data_i (word16[CFG_W-1:0]),
        .commit_i  (state_q == ST_COMMIT),
        .active_o  (cfg_o)
    );

    assign commit_o     = (state_q == ST_COMMIT);
    assign busy_o       = (state_q != ST_IDLE);
    assign cfg_loaded_o = loaded_q;
    assign err_o        = err_q;
    assign err_code_o   = code_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_clb_config_loader.sv
// Bench for clb_config_loader: frames are built from word lists, a frame-level
// model predicts the active bank, and a monitor checks cfg_o after each commit.
module tb_clb_config_loader;
    import fpga_cfg_pkg::*;

    localparam int NT = 16;
    localparam int CW = 13;
    localparam int W  = NT * CW;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  cfg;
    logic          cfg_loaded, commit, busy, err;
    logic [1:0]    err_code;
    loader_state_e state;

    clb_config_loader_if bus ();

    clb_config_loader #(.NUM_TILES(NT), .CFG_W(CW), .SYNC_BYTE(8'hA5)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_bus       (bus),
        .cfg_o        (cfg),
        .cfg_loaded_o (cfg_loaded),
        .commit_o     (commit),
        .busy_o       (busy),
        .err_o        (err),
        .err_code_o   (err_code),
        .state_o      (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters and reference model ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int gap_pct = 0;

    logic [CW-1:0] m_active [NT];
    logic          m_loaded;
    logic          m_err;
    logic [1:0]    m_code;
    logic [15:0]   fw [256];

    logic [W-1:0]  exp_q [$];
    logic          pend = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_flat();
        logic [W-1:0] v;
        for (int k = 0; k < NT; k++) v[k*CW +: CW] = m_active[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NT; k++) m_active[k] = '0;
        m_loaded = 1'b0;
        m_err    = 1'b0;
        m_code   = 2'b00;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("cfg_after_commit", cfg, exp_q.pop_front());
                pend = 1'b0;
            end
            if (commit) begin
                if (exp_q.size() == 0) check("unexpected_commit", 1, 0);
                else pend = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        for (int g = 0; g < 4 && $urandom_range(0, 99) < gap_pct; g++) begin
            @(negedge clk);
            bus.valid = 1'b0;
        end
        @(negedge clk);
        bus.valid = 1'b1;
        bus.data  = b;
        guard     = 0;
        while (!bus.ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.ready) check("handshake_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] g;
        for (int i = 0; i < n; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g);
        end
    endtask

    // Sends one frame built from fw[0..n-1]; pad_at < 0 means no pad error.
    task automatic send_frame(input int n, input int pad_at, input bit bad_chk);
        logic [7:0] chk, lo, hi;
        send_byte(8'hA5);
        m_err  = 1'b0;
        m_code = 2'b00;
        send_byte(8'(n));
        if (n == 0 || n > NT) begin
            m_err  = 1'b1;
            m_code = 2'b01;
            return;
        end
        chk = 8'(n);
        for (int i = 0; i < n; i++) begin
            lo = fw[i][7:0];
            hi = fw[i][15:8];
            if (i == pad_at) hi = hi | 8'h20;
            send_byte(lo);
            send_byte(hi);
            if (i == pad_at) begin
                m_err  = 1'b1;
                m_code = 2'b10;
                return;
            end
            chk = chk ^ lo ^ hi;
        end
        if (bad_chk) begin
            m_err  = 1'b1;
            m_code = 2'b11;
            send_byte(chk ^ 8'h01);
        end else begin
            for (int i = 0; i < n; i++) m_active[i] = fw[i][CW-1:0];
            m_loaded = 1'b1;
            exp_q.push_back(model_flat());
            send_byte(chk);
        end
    endtask

    task automatic check_after(input string tag);
        idle(3);
        check({tag, "_err"}, err, m_err);
        check({tag, "_code"}, err_code, m_code);
        check({tag, "_cfg"}, cfg, model_flat());
        check({tag, "_loaded"}, cfg_loaded, m_loaded);
        check({tag, "_busy"}, busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, kind;
        rst_n     = 1'b0;
        bus.valid = 1'b0;
        bus.data  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        check("rst_cfg", cfg, 0);
        check("rst_loaded", cfg_loaded, 0);
        check("rst_ready", bus.ready, 1);
        check("rst_err", err, 0);
        check("rst_commit", commit, 0);
        check("rst_state", state, ST_IDLE);

        // Full load.
        for (int k = 0; k < NT; k++) fw[k] = 16'h1000 | 16'(k);
        send_frame(16, -1, 0);
        check_after("full");
        check("full_tile5", cfg[5*CW +: CW], 13'h1005);

        // Partial load.
        fw[0] = 16'h0ABC;
        fw[1] = 16'h0001;
        send_frame(2, -1, 0);
        check_after("partial");
        check("partial_tile0", cfg[0 +: CW], 13'h0ABC);
        check("partial_tile2", cfg[2*CW +: CW], 13'h1002);

        // Checksum error, then a new sync clears err.
        send_frame(2, -1, 1);
        check_after("chk_err");
        send_byte(8'hA5);
        idle(1);
        check("sync_clears_err", err, 0);
        check("sync_busy", busy, 1);
        send_byte(8'h00);
        m_code = 2'b01;
        m_err  = 1'b1;
        check_after("count0");

        send_frame(17, -1, 0);
        check_after("count17");
        fw[0] = 16'h0000;
        send_frame(2, 0, 0);
        check_after("pad");

        // Randomized frames with gaps, garbage and injected errors.
        gap_pct = 30;
        for (int f = 0; f < 20; f++) begin
            send_garbage($urandom_range(0, 3));
            n    = $urandom_range(1, NT);
            kind = $urandom_range(0, 8);
            for (int i = 0; i < n; i++) fw[i] = 16'($urandom_range(0, 8191));
            if (kind == 6) send_frame(n, -1, 1);
            else if (kind == 7) send_frame(n, $urandom_range(0, n - 1), 0);
            else if (kind == 8) send_frame($urandom_range(17, 255), -1, 0);
            else send_frame(n, -1, 0);
            check_after("rand");
        end

        // Stalled full load matches the plain full load.
        for (int k = 0; k < NT; k++) fw[k] = 16'h1000 | 16'(k);
        send_garbage(3);
        send_frame(16, -1, 0);
        check_after("stall_full");

        // Reset after the 5th word of a frame.
        gap_pct = 0;
        send_byte(8'hA5);
        send_byte(8'd16);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h33);
            send_byte(8'h01);
        end
        @(negedge clk);
        bus.valid = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        idle(2);
        check("midrst_cfg", cfg, 0);
        check("midrst_state", state, ST_IDLE);
        check("midrst_loaded", cfg_loaded, 0);
        rst_n = 1'b1;
        idle(2);
        fw[0] = 16'h1FFF;
        send_frame(1, -1, 0);
        check_after("post_rst");

        check("exp_q_drained", exp_q.size() + int'(pend), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
